serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL provide ports (clock and reset first):
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to add a, b, cin; sampled only when idle or done
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse marking a new valid result
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin
- cout  output  1  registered carry-out of a+b+cin
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL add LSB-first, one bit per cycle, through a single 1-bit full-adder cell plus a carry flip-flop.
REQ-005 SHALL implement states IDLE, RUN, DONE; encoding 2 bits.
REQ-006 IDLE: start=1 -> capture a, b into shift registers, cin into carry FF, bit counter=0, go RUN; start=0 -> stay.
REQ-007 RUN: each cycle, shift one sum bit into result shift register, update carry FF, shift operands right, increment counter.
REQ-008 RUN: after the cycle processing bit WIDTH-1 -> go DONE; load sum and cout output registers on that same edge.
REQ-009 DONE: done=1 for exactly this one cycle; start=1 -> accepted as in IDLE (back-to-back, no bubble); start=0 -> go IDLE.
REQ-010 Latency: start accepted on edge k -> busy=1 during cycles k+1..k+WIDTH -> done=1 during cycle k+WIDTH+1.
REQ-011 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both registered-state decodes, no combinational path from start.
REQ-012 start while busy=1 SHALL be ignored; captured operands SHALL not change mid-operation.
REQ-013 sum/cout SHALL hold previous result throughout RUN and IDLE, changing only on the REQ-008 edge.
REQ-014 Arithmetic: {cout,sum} SHALL equal a+b+cin modulo 2^(WIDTH+1); all-ones wrap produces cout=1, sum=a+b+cin-2^WIDTH.
REQ-015 Bit counter width SHALL be clog2(WIDTH+1); WIDTH=1 SHALL give RUN lasting exactly one cycle.
REQ-016 Inputs a, b, cin SHALL be don't-care except on the accepting edge.

Reset
REQ-017 rst=1 on an edge SHALL force state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, counter=0, shift registers=0.
REQ-018 rst SHALL take priority over start and over any RUN/DONE transition; reset mid-RUN aborts with no done pulse.
REQ-019 First start SHALL be accepted on the first edge with rst=0.

Structure
REQ-020 SHALL place state encodings (ST_IDLE=0, ST_RUN=1, ST_DONE=2) and default WIDTH in shared package serial_adder_pkg.
REQ-021 SHALL instantiate the team's existing FullAdder cell once as the only sub-module; datapath/FSM remain in serial_adder.
REQ-022 Target size: 120-250 lines RTL; no multipliers, no wide adder inferred.

Verification
REQ-023 WIDTH=8, a=3, b=5, cin=0 -> done exactly 9 cycles after start edge; sum=8, cout=0; busy high 8 cycles.
REQ-024 WIDTH=8, a=255, b=1, cin=0 -> sum=0, cout=1; a=255, b=255, cin=1 -> sum=255, cout=1.
REQ-025 start held high throughout RUN with changing a/b -> ignored; result equals first captured operands (a=10, b=20 -> sum=30).
REQ-026 Back-to-back: start=1 in DONE cycle with a=100, b=27 -> no IDLE cycle; second done 9 cycles later, sum=127; first sum held until then.
REQ-027 rst pulsed at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse; fresh start afterwards completes correctly.
REQ-028 Exhaustive WIDTH=1 and randomized WIDTH=8 (≥1000 ops) vs reference model a+b+cin -> zero mismatches.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Existing 1-bit full-adder cell used as the serial adder's only arithmetic element.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per cycle through a single full-adder cell
// and a carry flop; result registers update only when the last bit is processed.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic fa_sum;
    logic fa_cout;

    FullAdder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Shift-then-insert keeps the MSB write legal even when WIDTH is 1.
                res_sh_d           = res_sh_q >> 1;
                res_sh_d[WIDTH-1]  = fa_sum;
                carry_d            = fa_cout;
                a_sh_d             = a_sh_q >> 1;
                b_sh_d             = b_sh_q >> 1;
                cnt_d              = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_sh_d;
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus randomized
// WIDTH=8 operations and exhaustive WIDTH=1, against plain a+b+cin arithmetic.
module tb_serial_adder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       rst8, start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    // WIDTH=1 instance
    logic       rst1, start1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Expected currently-held results of each instance
    logic [7:0] hold_sum8  = '0;
    logic       hold_cout8 = 1'b0;
    logic [0:0] hold_sum1  = '0;
    logic       hold_cout1 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were set at the previous negedge; outputs settle after posedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue an operation on the 8-bit instance (must be in IDLE or DONE).
    // Ends in the done cycle with start deasserted.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input bit hold_start);
        logic [8:0] total;
        total  = 9'(av) + 9'(bv) + 9'(cv);
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("busy8_run", 64'(busy8), 64'd1);
            chk("done8_run", 64'(done8), 64'd0);
            chk("sum8_hold", 64'(sum8), 64'(hold_sum8));
            chk("cout8_hold", 64'(cout8), 64'(hold_cout8));
            start8 = hold_start;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            step();
        end
        start8 = 1'b0;
        hold_sum8  = total[7:0];
        hold_cout8 = total[8];
        chk("done8_pulse", 64'(done8), 64'd1);
        chk("busy8_done", 64'(busy8), 64'd0);
        chk("sum8_result", 64'(sum8), 64'(hold_sum8));
        chk("cout8_result", 64'(cout8), 64'(hold_cout8));
    endtask

    task automatic idle8();
        start8 = 1'b0;
        step();
        chk("done8_idle", 64'(done8), 64'd0);
        chk("busy8_idle", 64'(busy8), 64'd0);
        chk("sum8_idle", 64'(sum8), 64'(hold_sum8));
        chk("cout8_idle", 64'(cout8), 64'(hold_cout8));
    endtask

    task automatic op1(input logic av, input logic bv, input logic cv);
        logic [1:0] total;
        total  = 2'(av) + 2'(bv) + 2'(cv);
        start1 = 1'b1; a1 = av; b1 = bv; cin1 = cv;
        step();
        start1 = 1'b0;
        chk("busy1_run", 64'(busy1), 64'd1);
        chk("sum1_hold", 64'(sum1), 64'(hold_sum1));
        step();
        hold_sum1  = total[0];
        hold_cout1 = total[1];
        chk("done1_pulse", 64'(done1), 64'd1);
        chk("sum1_result", 64'(sum1), 64'(hold_sum1));
        chk("cout1_result", 64'(cout1), 64'(hold_cout1));
    endtask

    initial begin
        rst8 = 1'b1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        rst1 = 1'b1; start1 = 1'b1; a1 = 1'b1;  b1 = 1'b1;  cin1 = 1'b1;
        @(negedge clk);
        step();
        step();
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_sum8", 64'(sum8), 64'd0);
        chk("rst_cout8", 64'(cout8), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);

        // Start accepted on the very first edge with rst low; 3+5 -> 8
        rst8 = 1'b0; rst1 = 1'b0; start1 = 1'b0;
        op8(8'd3, 8'd5, 1'b0, 1'b0);
        idle8();

        op8(8'd255, 8'd1,   1'b0, 1'b0);
        idle8();
        op8(8'd255, 8'd255, 1'b1, 1'b0);
        idle8();

        // start held high during RUN must not disturb captured operands
        op8(8'd10, 8'd20, 1'b0, 1'b1);
        idle8();

        // Back-to-back: second start in the DONE cycle, no idle bubble
        op8(8'd7, 8'd9, 1'b1, 1'b0);
        op8(8'd100, 8'd27, 1'b0, 1'b0);
        idle8();

        // Reset in the middle of RUN aborts with no done pulse
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("mid_busy8", 64'(busy8), 64'd1);
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        hold_sum8 = '0; hold_cout8 = 1'b0;
        chk("abort_busy8", 64'(busy8), 64'd0);
        chk("abort_done8", 64'(done8), 64'd0);
        chk("abort_sum8", 64'(sum8), 64'd0);
        chk("abort_cout8", 64'(cout8), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abort_no_done8", 64'(done8), 64'd0);
        end
        op8(8'd77, 8'd88, 1'b1, 1'b0);
        idle8();

        // Exhaustive WIDTH=1, twice over so held values change
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 8; v++) begin
                logic [2:0] vv;
                vv = 3'(v);
                op1(vv[2], vv[1], vv[0]);
            end
        end

        // Randomized WIDTH=8, mixing back-to-back, idle gaps and held start
        for (int n = 0; n < 1000; n++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) idle8();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
